// File: rtl/cute_pkg.sv
// rtl/cute_pkg.sv - shared constants for the cute processor datapath and control unit
package cute_pkg;

  localparam int CUTE_DATA_W = 9;

  localparam logic [3:0] MUX_DIN = 4'd0;
  localparam logic [3:0] MUX_R0  = 4'd1;
  localparam logic [3:0] MUX_R1  = 4'd2;
  localparam logic [3:0] MUX_R2  = 4'd3;
  localparam logic [3:0] MUX_R3  = 4'd4;
  localparam logic [3:0] MUX_R4  = 4'd5;
  localparam logic [3:0] MUX_R5  = 4'd6;
  localparam logic [3:0] MUX_R6  = 4'd7;
  localparam logic [3:0] MUX_R7  = 4'd8;
  localparam logic [3:0] MUX_G   = 4'd9;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/cute_regfile.sv
// rtl/cute_regfile.sv - R0-R7 with per-register load enables, bus read port and registered debug read
module cute_regfile
  import cute_pkg::*;
#(
  parameter int DATA_W = CUTE_DATA_W
) (
  input  logic              clk,
  input  logic              Resetn,
  input  logic [DATA_W-1:0] wdata,
  input  logic [7:0]        rx,
  input  logic [2:0]        rsel,
  output logic [DATA_W-1:0] rdata,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] r [8];

  always_ff @(posedge clk) begin
    if (Resetn) begin
      for (int i = 0; i < 8; i++) r[i] <= '0;
      dbg_data <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (rx[i]) r[i] <= wdata;
      end
      dbg_data <= r[dbg_sel];
    end
  end

  assign rdata = r[rsel];

endmodule

// File: rtl/cute_datapath.sv
// rtl/cute_datapath.sv - cute datapath: bus mux, A/G registers, add/sub ALU; optional flags via CUTE_DP_FLAGS_EN
module cute_datapath
  import cute_pkg::*;
#(
  parameter int DATA_W = CUTE_DATA_W
) (
  input  logic              clk,
  input  logic              Resetn,
  input  logic [DATA_W-1:0] din,
  input  logic [3:0]        mux,
  input  logic [7:0]        rx,
  input  logic              a,
  input  logic              g,
  input  logic              alu,
  output logic [DATA_W-1:0] bus,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
`ifdef CUTE_DP_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_c
`endif
);

  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] g_reg;
  logic [DATA_W-1:0] rf_rdata;
  logic [2:0]        rf_rsel;
  logic [DATA_W-1:0] operand;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] result;

  // Codes 1..8 map onto R0..R7; only the low three bits of (code-1) matter.
  assign rf_rsel = 3'(mux - MUX_R0);

  cute_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk      (clk),
    .Resetn   (Resetn),
    .wdata    (bus),
    .rx       (rx),
    .rsel     (rf_rsel),
    .rdata    (rf_rdata),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always_comb begin
    bus = '0;
    if (mux == MUX_DIN)
      bus = din;
    else if (mux == MUX_G)
      bus = g_reg;
    else if (mux >= MUX_R0 && mux <= MUX_R7)
      bus = rf_rdata;
  end

  // Subtract as A + ~bus + 1 so the carry-out doubles as the no-borrow bit.
  assign operand = (alu == ALU_SUB) ? ~bus : bus;
  assign sum     = {1'b0, a_reg} + {1'b0, operand} + {{DATA_W{1'b0}}, alu};
  assign result  = sum[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (Resetn) begin
      a_reg <= '0;
      g_reg <= '0;
    end else begin
      if (a) a_reg <= bus;
      if (g) g_reg <= result;
    end
  end

`ifdef CUTE_DP_FLAGS_EN
  always_ff @(posedge clk) begin
    if (Resetn) begin
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else if (g) begin
      flag_z <= (result == '0);
      flag_c <= sum[DATA_W];
    end
  end
`else
  logic unused_carry;
  assign unused_carry = sum[DATA_W];
`endif

endmodule

// File: doc/cute_datapath.md
# cute_datapath

Register-transfer datapath of the cute processor, directly downstream of the control-unit FSM. Holds the eight general registers R0–R7, the ALU operand register A and the result register G, and one shared bus. Executes the per-cycle control word the FSM drives: bus source select, register load enables, A/G load strobes and add/sub select. Immediate data for MVI enters on `din`.

## Interface
Parameters:
- `DATA_W`, 9: width of `din`, the bus, R0–R7, A and G.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `Resetn`  in  1  synchronous, active-high reset (the name is historical; high = reset).
- `din`  in  DATA_W  immediate operand, bus source for mux code 0.
- `mux`  in  4  bus source select.
- `rx`  in  8  per-register load enables; bit i loads Ri from the bus; several bits may be set at once.
- `a`  in  1  load A from the bus.
- `g`  in  1  load G with the ALU result.
- `alu`  in  1  0 = A + bus, 1 = A − bus.
- `bus`  out  DATA_W  current bus value (combinational).
- `dbg_sel`  in  3  register index for readback.
- `dbg_data`  out  DATA_W  registered copy of R[`dbg_sel`].
- `flag_z`, `flag_c`  out  1  result flags; present only with `CUTE_DP_FLAGS_EN`.

## Operation
- Bus mux, combinational. Code 0 selects `din`. Codes 1–8 select R(code−1). Code 9 selects G. Codes 10–15 drive all-zero.
- ALU, combinational: `alu`=0 gives A + bus; `alu`=1 gives A + ~bus + 1. The result is truncated to DATA_W. The carry-out is bit DATA_W of the (DATA_W+1)-bit sum.
- Register load: on each edge, every Ri with `rx[i]`=1 takes the bus value. Registers with `rx[i]`=0 hold.
- A load: `a`=1 captures the bus into A.
- G load: `g`=1 captures the ALU result into G. The result is computed from A's pre-edge value, so `a`=1 and `g`=1 in the same cycle produce G = old A ± bus while A takes the bus.
- Self-reference: an Ri that is both the bus source and a load target re-loads its own old value.
- `dbg_data` is updated every cycle with R[`dbg_sel`] as seen before the edge.
- Reset (`Resetn`=1 at an edge): R0–R7, A, G, `dbg_data` and the flags all become 0. Reset wins over every simultaneous load. Reset asserted mid-instruction discards the partial result; there is no recovery state.
- The block has no internal FSM. Sequencing is owned entirely by the control unit; this block obeys the control word every cycle.

## Timing
- Bus is valid in the same cycle as `mux` and all source registers. Loads take effect at the next rising edge.
- ADD/SUB timeline as driven by the FSM:
  - Cycle 1: R[x]→A.
  - Cycle 2: A ± R[y]→G.
  - Cycle 3: G→R[x].
  - R[x] is visible one cycle after cycle 3.
- MV/MVI: the destination is updated at the edge ending the single execute cycle.
- `dbg_data` latency: 1 cycle from `dbg_sel` or from the register change.
- Reset values: `bus` = `din` if `mux`=0, otherwise 0 (all registers are 0); `dbg_data` = 0; `flag_z` = 0; `flag_c` = 0.

## Configuration
- `CUTE_DP_FLAGS_EN` defined:
  - `flag_z` and `flag_c` exist.
  - Both are registered and update only when `g`=1.
  - `flag_z` = (ALU result == 0).
  - `flag_c` = carry-out for add; for subtract it is the no-borrow bit (1 when A ≥ bus, unsigned).
  - Both hold when `g`=0.
- Undefined: the flag ports and flag logic are absent. All other behaviour is identical.

## Structure
- Shared package `cute_pkg` holds:
  - mux code constants MUX_DIN=0, MUX_R0=1 … MUX_R7=8, MUX_G=9;
  - ALU_ADD=0 and ALU_SUB=1;
  - the default data width constant.
- The control FSM imports the same package.
- One sub-module, `cute_regfile`, contains R0–R7 with the per-bit `rx` load enables, the 8:1 read for the bus mux and the registered debug read port.
- The bus mux, A, G and the ALU stay at top level.

## Test plan
- Reset: preload registers, assert `Resetn` for 1 cycle → all `dbg_data` reads return 0 and G=0 (bus with `mux`=9 reads 0).
- MVI: `din`=0x05A, `mux`=0, `rx`=0x08 for one cycle → R3=0x05A; all other registers remain 0.
- ADD: R1=0x003, R2=0x004, run the 3-cycle sequence → R1=0x007 one cycle later; R2 unchanged; `flag_z`=0 and `flag_c`=0 (flags build).
- SUB and wrap: R1=0x000, R2=0x001, SUB → R1=0x1FF; `flag_c`=0. Then R1=0x1FF plus R3=0x001, ADD → R1=0x000; `flag_z`=1 and `flag_c`=1.
- MV with multi-load: R5=0x0AA, `mux`=6, `rx`=0x21 → R0=R5=0x0AA. Also `a`=`g`=1 in the same cycle with A=2 and bus=3 → G=5 and A=3.
- Reset mid-ADD: assert `Resetn` in cycle 2 → G=0, A=0, the destination register is 0, and no stale write occurs afterwards.
